fp_mul_pipe: RTL and testbench

FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

---
 rtl/fp_mul_pipe.sv | 131 +++++++++++++
 tb/tb_fp_mul_pipe.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - 3-stage signed fixed-point multiplier with round/align and overflow handling
// Optional macro FP_MUL_SAT_EN: clamp overflowing results instead of wrapping them.
module fp_mul_pipe #(
   parameter int INT1     = 6,
   parameter int FRAC1    = 8,
   parameter int INT2     = 6,
   parameter int FRAC2    = 8,
   parameter int OUT_INT  = 6,
   parameter int OUT_FRAC = 12
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [INT1+FRAC1-1:0]       a,
   input  logic [INT2+FRAC2-1:0]       b,
   input  logic                        rnd_mode,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [OUT_INT+OUT_FRAC-1:0] product,
   output logic                        ovf,
   output logic                        ovf_sticky,
   input  logic                        clr_sticky
);

   localparam int AW = INT1 + FRAC1;
   localparam int BW = INT2 + FRAC2;
   localparam int PW = AW + BW;
   localparam int PF = FRAC1 + FRAC2;
   localparam int OW = OUT_INT + OUT_FRAC;
   localparam int EW = PW + OW + 2;

   logic [AW-1:0]        r_a;
   logic [BW-1:0]        r_b;
   logic                 r_rnd1;
   logic                 r_v1;
   logic signed [PW-1:0] r_p;
   logic                 r_rnd2;
   logic                 r_v2;
   logic [OW-1:0]        r_product;
   logic                 r_ovf;
   logic                 r_v3;
   logic                 r_sticky;

   logic                 w_adv1;
   logic                 w_adv2;
   logic                 w_adv3;
   logic signed [PW-1:0] w_mul;
   logic signed [EW-1:0] w_ext;
   logic signed [EW-1:0] w_al;
   logic [EW-OW:0]       w_hi;
   logic                 w_ovf;
   logic [OW-1:0]        w_res;

   assign w_adv3   = !r_v3 || out_ready;
   assign w_adv2   = !r_v2 || w_adv3;
   assign w_adv1   = !r_v1 || w_adv2;
   assign in_ready = w_adv1 && !reset;

   assign w_mul = $signed({{BW{r_a[AW-1]}}, r_a}) * $signed({{AW{r_b[BW-1]}}, r_b});
   assign w_ext = {{(EW-PW){r_p[PW-1]}}, r_p};

   // Wide intermediate keeps the rounding carry visible to the range check.
   generate
      if (PF > OUT_FRAC) begin : g_round
         localparam int D = PF - OUT_FRAC;
         logic [EW-1:0]        w_half;
         logic signed [EW-1:0] w_sum;
         assign w_half = {{(EW-1){1'b0}}, 1'b1} << (D - 1);
         assign w_sum  = w_ext + (r_rnd2 ? w_half : '0);
         assign w_al   = w_sum >>> D;
      end else begin : g_pad
         assign w_al = w_ext <<< (OUT_FRAC - PF);
      end
   endgenerate

   assign w_hi  = w_al[EW-1:OW-1];
   assign w_ovf = !((&w_hi) || !(|w_hi));

`ifdef FP_MUL_SAT_EN
   assign w_res = !w_ovf      ? w_al[OW-1:0] :
                  r_p[PW-1]   ? {1'b1, {(OW-1){1'b0}}} :
                                {1'b0, {(OW-1){1'b1}}};
`else
   assign w_res = w_al[OW-1:0];
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a       <= '0;
         r_b       <= '0;
         r_rnd1    <= 1'b0;
         r_v1      <= 1'b0;
         r_p       <= '0;
         r_rnd2    <= 1'b0;
         r_v2      <= 1'b0;
         r_product <= '0;
         r_ovf     <= 1'b0;
         r_v3      <= 1'b0;
         r_sticky  <= 1'b0;
      end else begin
         if (w_adv1) begin
            r_v1   <= in_valid;
            r_a    <= a;
            r_b    <= b;
            r_rnd1 <= rnd_mode;
         end
         if (w_adv2) begin
            r_v2   <= r_v1;
            r_p    <= w_mul;
            r_rnd2 <= r_rnd1;
         end
         if (w_adv3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
               r_product <= w_res;
               r_ovf     <= w_ovf;
            end
         end
         // A delivered overflow takes priority over a same-cycle clear.
         if (r_v3 && out_ready && r_ovf) r_sticky <= 1'b1;
         else if (clr_sticky)            r_sticky <= 1'b0;
      end
   end

   assign out_valid  = r_v3;
   assign product    = r_product;
   assign ovf        = r_ovf;
   assign ovf_sticky = r_sticky;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb/tb_fp_mul_pipe.sv - directed self-checking bench for fp_mul_pipe (default parameters)
module tb_fp_mul_pipe;

`ifdef FP_MUL_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [13:0] a;
   logic [13:0] b;
   logic        rnd_mode;
   logic        out_valid;
   logic        out_ready;
   logic [17:0] product;
   logic        ovf;
   logic        ovf_sticky;
   logic        clr_sticky;

   int n_vec = 0;
   int n_err = 0;

   fp_mul_pipe dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .rnd_mode   (rnd_mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .product    (product),
      .ovf        (ovf),
      .ovf_sticky (ovf_sticky),
      .clr_sticky (clr_sticky)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One isolated transaction; also checks the 3-cycle latency.
   task automatic run_one(input string tag, input logic [13:0] va, input logic [13:0] vb,
                          input logic vr, input int ep, input logic eo);
      logic [17:0] e;
      e = ep[17:0];
      in_valid = 1'b1; a = va; b = vb; rnd_mode = vr; out_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
      @(posedge clk); @(negedge clk);
      chk({tag, "_lat2"}, 32'(out_valid), 32'd0);
      @(posedge clk); @(negedge clk);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_product"}, 32'(product), 32'(e));
      chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
      @(posedge clk); #1;
   endtask

   initial begin
      int          sent;
      int          recv;
      int          last_rx;
      int          stale;
      logic [17:0] e;

      reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; rnd_mode = 1'b0;
      out_ready = 1'b0; clr_sticky = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_product", 32'(product), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_sticky", 32'(ovf_sticky), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      #1 chk("rel_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      run_one("mul_1p5x2", 14'h0180, 14'h0200, 1'b0, 12288, 1'b0);
      chk("sticky_idle", 32'(ovf_sticky), 32'd0);
      run_one("neg", 14'h3F00, 14'h0080, 1'b0, -2048, 1'b0);
      run_one("tiny_trunc", 14'd3, 14'd3, 1'b0, 0, 1'b0);
      run_one("tiny_round", 14'd3, 14'd3, 1'b1, 1, 1'b0);
      run_one("neg_trunc", 14'h3FFF, 14'd8, 1'b0, -1, 1'b0);
      run_one("neg_round", 14'h3FFF, 14'd8, 1'b1, 0, 1'b0);
      run_one("min_fits", 14'h2000, 14'h0100, 1'b0, -131072, 1'b0);
      run_one("ovf_pos", 14'h1F00, 14'h1F00, 1'b0, SAT ? 131071 : 4096, 1'b1);
      chk("sticky_set", 32'(ovf_sticky), 32'd1);

      clr_sticky = 1'b1;
      @(posedge clk); #1;
      clr_sticky = 1'b0;
      chk("sticky_clr", 32'(ovf_sticky), 32'd0);

      clr_sticky = 1'b1;
      run_one("ovf_neg", 14'h2000, 14'h0200, 1'b0, SAT ? -131072 : 0, 1'b1);
      chk("sticky_set_wins", 32'(ovf_sticky), 32'd1);
      clr_sticky = 1'b1;
      @(posedge clk); #1;
      clr_sticky = 1'b0;

      run_one("edge_trunc", 14'd4104, 14'd511, 1'b0, 131071, 1'b0);
      chk("sticky_no_ovf", 32'(ovf_sticky), 32'd0);
      run_one("edge_carry", 14'd4104, 14'd511, 1'b1, SAT ? 131071 : -131072, 1'b1);
      chk("sticky_carry", 32'(ovf_sticky), 32'd1);

      // Six back-to-back inputs with the sink stalled for the first five cycles.
      sent = 0; recv = 0; last_rx = -1;
      for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
         in_valid  = (sent < 6);
         a         = 14'((sent + 1) * 256);
         b         = 14'h0180;
         rnd_mode  = 1'b0;
         out_ready = (cyc >= 5);
         @(negedge clk);
         if (cyc == 4) begin
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_accepted", 32'(sent), 32'd3);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_hold", 32'(product), 32'd6144);
         end
         if (out_valid && out_ready) begin
            e = 18'((recv + 1) * 6144);
            chk($sformatf("stall_rx%0d", recv), 32'(product), 32'(e));
            recv++;
            last_rx = cyc;
         end
         if (in_valid && in_ready) sent++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("stall_rx_count", 32'(recv), 32'd6);
      chk("stall_throughput", 32'(last_rx), 32'd10);

      // Reset with two results in flight.
      out_ready = 1'b1; in_valid = 1'b1; a = 14'h0100; b = 14'h0100;
      @(posedge clk); #1;
      a = 14'h0200;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("pre_rst_sticky", 32'(ovf_sticky), 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("async_out_valid", 32'(out_valid), 32'd0);
      chk("async_sticky", 32'(ovf_sticky), 32'd0);
      chk("async_product", 32'(product), 32'd0);
      chk("async_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1 chk("rel2_in_ready", 32'(in_ready), 32'd1);
      stale = 0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      chk("no_stale", 32'(stale), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
